parity_push_stage: RTL and testbench

Upstream feeder for the parity-protected FIFO. It accepts raw DATA_WIDTH-bit words from a producer, appends a parity bit, and drives the FIFO push port through a 2-entry skid buffer. Full throughput is one word per clock, with 1-cycle latency. The block also provides deliberate parity-error injection and transfer counters, so the FIFO's corrupt-data discard path can be exercised in-system.

---
 rtl/parity_push_stage.sv | 164 ++++++++++++++++
 tb/tb_parity_push_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_push_stage.sv
// Parity-encoding feeder for the parity-protected FIFO: appends a parity bit, buffers
// through a 2-entry skid stage, supports deliberate parity corruption and counts transfers.
module parity_push_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int EVEN_ODD   = 0,
  parameter int PARITY_BIT = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_grant_o,
  input  logic                  inj_err_i,
  output logic [DATA_WIDTH:0]   push_data_o,
  output logic                  push_valid_o,
  input  logic                  push_grant_i,
  output logic [CNT_WIDTH-1:0]  word_cnt_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o
);

  localparam int   WORD_WIDTH = DATA_WIDTH + 1;
  localparam logic ODD_SENSE  = (EVEN_ODD != 0);
  localparam logic PARITY_LSB = (PARITY_BIT != 0);

  function automatic logic [WORD_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] data,
                                                   input logic corrupt);
    logic p;
    p = (^data) ^ ODD_SENSE ^ corrupt;
    if (PARITY_LSB) begin
      encode = {data, p};
    end else begin
      encode = {p, data};
    end
  endfunction

  logic [WORD_WIDTH-1:0] main_data_q, main_data_d;
  logic                  main_valid_q, main_valid_d;
  logic                  main_corrupt_q, main_corrupt_d;
  logic [WORD_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic                  skid_corrupt_q, skid_corrupt_d;
  logic                  grant_q, grant_d;
  logic                  armed_q, armed_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

  logic                  accept_s;
  logic                  drain_s;
  logic                  corrupt_s;
  logic [WORD_WIDTH-1:0] word_s;

  assign accept_s  = in_valid_i && grant_q;
  assign drain_s   = main_valid_q && push_grant_i;
  assign corrupt_s = armed_q || inj_err_i;
  assign word_s    = encode(in_data_i, corrupt_s);

  // Buffer occupancy (EMPTY / ONE / TWO follows from the two valid bits) and next grant
  always_comb begin
    main_data_d    = main_data_q;
    main_valid_d   = main_valid_q;
    main_corrupt_d = main_corrupt_q;
    skid_data_d    = skid_data_q;
    skid_valid_d   = skid_valid_q;
    skid_corrupt_d = skid_corrupt_q;

    if (skid_valid_q) begin
      // TWO: grant is low, so only a drain can happen; skid slides into main
      if (drain_s) begin
        main_data_d    = skid_data_q;
        main_valid_d   = 1'b1;
        main_corrupt_d = skid_corrupt_q;
        skid_data_d    = '0;
        skid_valid_d   = 1'b0;
        skid_corrupt_d = 1'b0;
      end else begin
        main_valid_d   = main_valid_q;
      end
    end else if (main_valid_q) begin
      if (accept_s && drain_s) begin
        main_data_d    = word_s;
        main_valid_d   = 1'b1;
        main_corrupt_d = corrupt_s;
      end else if (accept_s) begin
        skid_data_d    = word_s;
        skid_valid_d   = 1'b1;
        skid_corrupt_d = corrupt_s;
      end else if (drain_s) begin
        main_data_d    = '0;
        main_valid_d   = 1'b0;
        main_corrupt_d = 1'b0;
      end else begin
        main_valid_d   = main_valid_q;
      end
    end else if (accept_s) begin
      main_data_d    = word_s;
      main_valid_d   = 1'b1;
      main_corrupt_d = corrupt_s;
    end else begin
      main_valid_d   = main_valid_q;
    end

    grant_d = !skid_valid_d;
  end

  // Sticky corruption request, consumed by the next accepted word
  always_comb begin
    if (accept_s) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q || inj_err_i;
    end
  end

  // Transfer counters, wrapping naturally at their width
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (drain_s) begin
      word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
      if (main_corrupt_q) begin
        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  // State registers; reset discards any buffered words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_q    <= '0;
      main_valid_q   <= 1'b0;
      main_corrupt_q <= 1'b0;
      skid_data_q    <= '0;
      skid_valid_q   <= 1'b0;
      skid_corrupt_q <= 1'b0;
      grant_q        <= 1'b0;
      armed_q        <= 1'b0;
      word_cnt_q     <= '0;
      err_cnt_q      <= '0;
    end else begin
      main_data_q    <= main_data_d;
      main_valid_q   <= main_valid_d;
      main_corrupt_q <= main_corrupt_d;
      skid_data_q    <= skid_data_d;
      skid_valid_q   <= skid_valid_d;
      skid_corrupt_q <= skid_corrupt_d;
      grant_q        <= grant_d;
      armed_q        <= armed_d;
      word_cnt_q     <= word_cnt_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign in_grant_o   = grant_q;
  assign push_data_o  = main_data_q;
  assign push_valid_o = main_valid_q;
  assign word_cnt_o   = word_cnt_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_parity_push_stage.sv
// Randomized self-checking bench for parity_push_stage: two instances (even/MSB/16-bit
// counters and odd/LSB/4-bit counters) share stimulus and are compared to a queue model.
module tb_parity_push_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        inj = 1'b0;
  logic        push_grant = 1'b0;

  logic        grant_a, pvalid_a, grant_b, pvalid_b;
  logic [32:0] pdata_a, pdata_b;
  logic [15:0] wcnt_a, ecnt_a;
  logic [3:0]  wcnt_b, ecnt_b;

  always #5 clk = ~clk;

  parity_push_stage #(.DATA_WIDTH(32), .EVEN_ODD(0), .PARITY_BIT(0), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_grant_o(grant_a),
    .inj_err_i(inj), .push_data_o(pdata_a), .push_valid_o(pvalid_a), .push_grant_i(push_grant),
    .word_cnt_o(wcnt_a), .err_cnt_o(ecnt_a));

  parity_push_stage #(.DATA_WIDTH(32), .EVEN_ODD(1), .PARITY_BIT(1), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_grant_o(grant_b),
    .inj_err_i(inj), .push_data_o(pdata_b), .push_valid_o(pvalid_b), .push_grant_i(push_grant),
    .word_cnt_o(wcnt_b), .err_cnt_o(ecnt_b));

  typedef struct { logic [31:0] d; bit c; } ent_t;
  ent_t        mq[$];
  logic [32:0] got_a[$];
  logic [32:0] got_b[$];
  int nchk = 0;
  int nerr = 0;
  int m_words, m_errs;
  bit m_armed, m_grant, m_acc;

  // Even parity in the MSB: parity bit set when the payload has an odd number of ones
  function automatic logic [32:0] enc_a(logic [31:0] d, bit c);
    bit p;
    p = (($countones(d) % 2) == 1) ^ c;
    return {p, d};
  endfunction

  // Odd parity in the LSB: parity bit set when the payload has an even number of ones
  function automatic logic [32:0] enc_b(logic [31:0] d, bit c);
    bit p;
    p = (($countones(d) % 2) == 0) ^ c;
    return {d, p};
  endfunction

  task automatic model_reset();
    mq.delete(); got_a.delete(); got_b.delete();
    m_words = 0; m_errs = 0; m_armed = 1'b0; m_grant = 1'b0; m_acc = 1'b0;
  endtask

  // One clock: capture DUT words leaving, then advance the queue model
  task automatic tick();
    bit acc, drn;
    ent_t e;
    acc = in_valid && m_grant;
    drn = (mq.size() > 0) && push_grant;
    if (drn) begin
      got_a.push_back(pdata_a);
      got_b.push_back(pdata_b);
    end
    @(posedge clk);
    if (drn) begin
      e = mq.pop_front();
      m_words++;
      if (e.c) m_errs++;
    end
    if (acc) begin
      e.d = in_data;
      e.c = m_armed || inj;
      mq.push_back(e);
      m_armed = 1'b0;
    end else if (inj) begin
      m_armed = 1'b1;
    end
    m_grant = (mq.size() < 2);
    m_acc = acc;
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    nchk++; if ({grant_a, pvalid_a, pdata_a, wcnt_a, ecnt_a} !== '0) begin nerr++;
      $display("FAIL reset_outs_a got %b %b %h %h %h exp all 0", grant_a, pvalid_a, pdata_a, wcnt_a, ecnt_a); end
    nchk++; if ({grant_b, pvalid_b, pdata_b, wcnt_b, ecnt_b} !== '0) begin nerr++;
      $display("FAIL reset_outs_b got %b %b %h %h %h exp all 0", grant_b, pvalid_b, pdata_b, wcnt_b, ecnt_b); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    nchk++; if (grant_a !== 1'b0) begin nerr++; $display("FAIL grant_before_edge got %b exp 0", grant_a); end
    tick();
    nchk++; if (grant_a !== 1'b1 || grant_b !== 1'b1) begin nerr++;
      $display("FAIL grant_after_release got %b/%b exp 1/1", grant_a, grant_b); end
    nchk++; if (pvalid_a !== 1'b0) begin nerr++; $display("FAIL valid_after_release got %b exp 0", pvalid_a); end
  endtask

  task automatic test_backpressure();
    got_a.delete();
    push_grant = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_data = 32'h33; tick(); tick();
    nchk++; if (pdata_a !== enc_a(32'h11, 1'b0) || pvalid_a !== 1'b1) begin nerr++;
      $display("FAIL bp_hold_a got %b %h exp 1 %h", pvalid_a, pdata_a, enc_a(32'h11, 1'b0)); end
    nchk++; if (grant_a !== 1'b0 || grant_b !== 1'b0) begin nerr++;
      $display("FAIL bp_grant_low got %b/%b exp 0/0", grant_a, grant_b); end
    push_grant = 1'b1;
    for (int i = 0; i < 20 && got_a.size() < 3; i++) begin
      tick();
      if (m_acc) in_valid = 1'b0;
    end
    nchk++; if (got_a.size() !== 3) begin nerr++;
      $display("FAIL bp_delivered_count got %0d exp 3", got_a.size()); end
    if (got_a.size() >= 3) begin
      nchk++; if (got_a[0] !== enc_a(32'h11, 1'b0) || got_a[1] !== enc_a(32'h22, 1'b0) ||
                  got_a[2] !== enc_a(32'h33, 1'b0)) begin nerr++;
        $display("FAIL bp_order got %h %h %h exp %h %h %h", got_a[0], got_a[1], got_a[2],
                 enc_a(32'h11, 1'b0), enc_a(32'h22, 1'b0), enc_a(32'h33, 1'b0)); end
      nchk++; if (got_b[0] !== enc_b(32'h11, 1'b0) || got_b[2] !== enc_b(32'h33, 1'b0)) begin nerr++;
        $display("FAIL bp_order_b got %h %h exp %h %h", got_b[0], got_b[2],
                 enc_b(32'h11, 1'b0), enc_b(32'h33, 1'b0)); end
    end
    nchk++; if (wcnt_a !== 16'd3) begin nerr++; $display("FAIL bp_word_cnt got %0d exp 3", wcnt_a); end
  endtask

  task automatic test_encoding();
    push_grant = 1'b1;
    in_valid = 1'b1; in_data = 32'h00000003; tick(); in_valid = 1'b0;
    nchk++; if (pdata_a !== 33'h0_00000003) begin nerr++; $display("FAIL enc_even_3 got %h exp 0_00000003", pdata_a); end
    nchk++; if (pdata_b !== {32'h00000003, 1'b1}) begin nerr++; $display("FAIL enc_odd_3 got %h exp %h", pdata_b, {32'h00000003, 1'b1}); end
    tick();
    in_valid = 1'b1; in_data = 32'h00000001; tick(); in_valid = 1'b0;
    nchk++; if (pdata_a !== 33'h1_00000001) begin nerr++; $display("FAIL enc_even_1 got %h exp 1_00000001", pdata_a); end
    nchk++; if (pdata_b !== {32'h00000001, 1'b0}) begin nerr++; $display("FAIL enc_odd_1 got %h exp %h", pdata_b, {32'h00000001, 1'b0}); end
    tick();
  endtask

  task automatic test_injection();
    push_grant = 1'b1;
    inj = 1'b1; tick(); inj = 1'b0;
    in_valid = 1'b1; in_data = 32'h00000001; tick(); in_valid = 1'b0;
    nchk++; if (pdata_a !== 33'h0_00000001) begin nerr++; $display("FAIL inj_word got %h exp 0_00000001", pdata_a); end
    tick();
    nchk++; if (ecnt_a !== 16'd1) begin nerr++; $display("FAIL inj_err_cnt got %0d exp 1", ecnt_a); end
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    nchk++; if (pdata_a !== 33'h1_00000001) begin nerr++; $display("FAIL inj_next_clean got %h exp 1_00000001", pdata_a); end
    tick();
    nchk++; if (ecnt_a !== 16'd1 || ecnt_b !== 4'd1) begin nerr++;
      $display("FAIL inj_err_cnt_hold got %0d/%0d exp 1/1", ecnt_a, ecnt_b); end
  endtask

  task automatic test_inj_stack();
    logic [31:0] d1, d2, d3, d4;
    int e_base;
    push_grant = 1'b1;
    got_a.delete();
    d1 = $urandom; d2 = $urandom;
    inj = 1'b1; in_valid = 1'b1; in_data = d1; tick(); inj = 1'b0;
    in_data = d2; tick(); in_valid = 1'b0;
    nchk++; if (got_a.size() != 1 || got_a[0] !== enc_a(d1, 1'b1)) begin nerr++;
      $display("FAIL same_cycle_inj got %h exp %h", got_a.size() > 0 ? got_a[0] : 33'h0, enc_a(d1, 1'b1)); end
    nchk++; if (pdata_a !== enc_a(d2, 1'b0)) begin nerr++;
      $display("FAIL same_cycle_flag_clear got %h exp %h", pdata_a, enc_a(d2, 1'b0)); end
    tick();
    e_base = m_errs;
    got_a.delete();
    repeat (3) begin inj = 1'b1; tick(); inj = 1'b0; tick(); end
    d3 = $urandom; d4 = $urandom;
    in_valid = 1'b1; in_data = d3; tick(); in_data = d4; tick(); in_valid = 1'b0; tick();
    nchk++; if (got_a.size() != 2 || got_a[0] !== enc_a(d3, 1'b1) || got_a[1] !== enc_a(d4, 1'b0)) begin nerr++;
      $display("FAIL stacked_inj_words got %0d words exp %h %h", got_a.size(), enc_a(d3, 1'b1), enc_a(d4, 1'b0)); end
    nchk++; if (ecnt_a !== 16'(e_base + 1)) begin nerr++;
      $display("FAIL stacked_inj_cnt got %0d exp %0d", ecnt_a, e_base + 1); end
  endtask

  task automatic test_streaming();
    int base;
    base = m_words;
    push_grant = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = $urandom; in_valid = 1'b1;
      inj = ($urandom_range(0, 7) == 0);
      if (i > 0) begin
        nchk++; if (pvalid_a !== 1'b1 || grant_a !== 1'b1) begin nerr++;
          $display("FAIL stream_rate cyc %0d got valid %b grant %b exp 1 1", i, pvalid_a, grant_a); end
        nchk++; if (pdata_a !== enc_a(mq[0].d, mq[0].c) || pdata_b !== enc_b(mq[0].d, mq[0].c)) begin nerr++;
          $display("FAIL stream_data cyc %0d got %h/%h exp %h/%h", i, pdata_a, pdata_b,
                   enc_a(mq[0].d, mq[0].c), enc_b(mq[0].d, mq[0].c)); end
      end
      tick();
    end
    in_valid = 1'b0; inj = 1'b0; tick();
    nchk++; if (wcnt_a !== 16'(base + 100)) begin nerr++;
      $display("FAIL stream_word_cnt got %0d exp %0d", wcnt_a, base + 100); end
    nchk++; if (ecnt_a !== m_errs[15:0] || ecnt_b !== m_errs[3:0]) begin nerr++;
      $display("FAIL stream_err_cnt got %0d/%0d exp %0d", ecnt_a, ecnt_b, m_errs); end
  endtask

  task automatic test_random_bp();
    for (int i = 0; i < 300; i++) begin
      in_data = $urandom; in_valid = $urandom_range(0, 1);
      push_grant = ($urandom_range(0, 2) != 0);
      inj = ($urandom_range(0, 9) == 0);
      nchk++; if (pvalid_a !== (mq.size() > 0) || grant_a !== m_grant || grant_b !== m_grant) begin nerr++;
        $display("FAIL rand_ctrl cyc %0d got v%b g%b/%b exp v%b g%b", i, pvalid_a, grant_a, grant_b, mq.size() > 0, m_grant); end
      if (mq.size() > 0) begin
        nchk++; if (pdata_a !== enc_a(mq[0].d, mq[0].c) || pdata_b !== enc_b(mq[0].d, mq[0].c)) begin nerr++;
          $display("FAIL rand_data cyc %0d got %h/%h exp %h/%h", i, pdata_a, pdata_b,
                   enc_a(mq[0].d, mq[0].c), enc_b(mq[0].d, mq[0].c)); end
      end
      tick();
    end
    in_valid = 1'b0; inj = 1'b0; push_grant = 1'b1;
    repeat (3) tick();
    nchk++; if (wcnt_a !== m_words[15:0] || wcnt_b !== m_words[3:0]) begin nerr++;
      $display("FAIL rand_word_cnt got %0d/%0d exp %0d", wcnt_a, wcnt_b, m_words); end
    nchk++; if (ecnt_a !== m_errs[15:0] || ecnt_b !== m_errs[3:0]) begin nerr++;
      $display("FAIL rand_err_cnt got %0d/%0d exp %0d", ecnt_a, ecnt_b, m_errs); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] dn;
    push_grant = 1'b0;
    in_valid = 1'b1; in_data = $urandom; tick(); in_data = $urandom; tick(); in_valid = 1'b0;
    nchk++; if (pvalid_a !== 1'b1 || grant_a !== 1'b0) begin nerr++;
      $display("FAIL mid_pre_full got v%b g%b exp v1 g0", pvalid_a, grant_a); end
    #3 rst = 1'b1;
    #1;
    nchk++; if ({grant_a, pvalid_a, pdata_a, wcnt_a, ecnt_a} !== '0 ||
                {grant_b, pvalid_b, pdata_b, wcnt_b, ecnt_b} !== '0) begin nerr++;
      $display("FAIL mid_reset_outs got %b %b %h %h / %b %b %h exp all 0", grant_a, pvalid_a, pdata_a, wcnt_a,
               grant_b, pvalid_b, pdata_b); end
    #1 rst = 1'b0;
    model_reset();
    dn = $urandom;
    in_valid = 1'b1; in_data = dn; tick();
    nchk++; if (grant_a !== 1'b1 || pvalid_a !== 1'b0 || pdata_a !== 33'h0) begin nerr++;
      $display("FAIL mid_after_release got g%b v%b %h exp g1 v0 0", grant_a, pvalid_a, pdata_a); end
    push_grant = 1'b1;
    tick(); in_valid = 1'b0;
    nchk++; if (pvalid_a !== 1'b1 || pdata_a !== enc_a(dn, 1'b0)) begin nerr++;
      $display("FAIL mid_fresh_word got v%b %h exp v1 %h", pvalid_a, pdata_a, enc_a(dn, 1'b0)); end
    tick();
    nchk++; if (wcnt_a !== 16'd1) begin nerr++; $display("FAIL mid_word_cnt got %0d exp 1", wcnt_a); end
  endtask

  task automatic test_wrap();
    #3 rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    tick();
    push_grant = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = $urandom; tick();
    end
    in_valid = 1'b0; tick();
    nchk++; if (wcnt_b !== 4'd1) begin nerr++; $display("FAIL wrap_cnt4 got %0d exp 1", wcnt_b); end
    nchk++; if (wcnt_a !== 16'd17) begin nerr++; $display("FAIL wrap_cnt16 got %0d exp 17", wcnt_a); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_encoding();
    test_injection();
    test_inj_stack();
    test_streaming();
    test_random_bp();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
